// File: rtl/fetch_pc_sequencer.sv
// Program-counter sequencer: picks the next PC (boot, sequential, branch, trap),
// drives the PC register enable, parks redirects across stalls and halts on budget.
module fetch_pc_sequencer #(
  parameter logic [63:0] RESET_VEC   = 64'h0,
  parameter int unsigned INSTR_BYTES = 4,
  parameter int unsigned MAX_FETCH   = 100,
  localparam int unsigned CNT_W      = $clog2(MAX_FETCH + 2)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [63:0]      pc_cur_i,
  input  logic             imem_ready_i,
  input  logic             stall_i,
  input  logic             branch_valid_i,
  input  logic [63:0]      branch_target_i,
  input  logic             trap_valid_i,
  input  logic [63:0]      trap_target_i,
  input  logic             halt_i,
  output logic [63:0]      pc_next_o,
  output logic             pc_en_o,
  output logic             flush_o,
  output logic             misalign_o,
  output logic [CNT_W-1:0] fetch_count_o,
  output logic             halted_o
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_WAIT, S_HALT} state_e;

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_FETCH);

  state_e           state_q, state_d;
  logic [63:0]      pend_q, pend_d;
  logic             mis_q, mis_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      seq_pc, redir_tgt, next_pc;
  logic             adv, redir, load, flush;

  function automatic logic [63:0] align4(input logic [63:0] a);
    return {a[63:2], 2'b00};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

  assign adv       = imem_ready_i & ~stall_i;
  assign seq_pc    = pc_cur_i + 64'(INSTR_BYTES);
  assign redir     = trap_valid_i | branch_valid_i;
  assign redir_tgt = trap_valid_i ? trap_target_i : branch_target_i;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    mis_d   = mis_q;
    cnt_d   = cnt_q;
    next_pc = seq_pc;
    load    = 1'b0;
    flush   = 1'b0;
    case (state_q)
      S_BOOT: begin
        next_pc = RESET_VEC;
        load    = ~reset_i;
        state_d = halt_i ? S_HALT : S_RUN;
      end
      S_RUN: begin
        if (halt_i) begin
          state_d = S_HALT;
        end else if (redir) begin
          mis_d = mis_q | (redir_tgt[1:0] != 2'b00);
          if (adv) begin
            next_pc = align4(redir_tgt);
            load    = 1'b1;
            flush   = 1'b1;
          end else begin
            pend_d  = align4(redir_tgt);
            state_d = S_WAIT;
          end
        end else begin
          load = adv;
        end
      end
      S_WAIT: begin
        // A fresh trap always supersedes the parked target; a repeated branch does not.
        if (halt_i) begin
          pend_d  = '0;
          state_d = S_HALT;
        end else if (adv) begin
          next_pc = trap_valid_i ? align4(trap_target_i) : pend_q;
          load    = 1'b1;
          flush   = 1'b1;
          pend_d  = '0;
          state_d = S_RUN;
          if (trap_valid_i) mis_d = mis_q | (trap_target_i[1:0] != 2'b00);
        end else if (trap_valid_i) begin
          pend_d = align4(trap_target_i);
          mis_d  = mis_q | (trap_target_i[1:0] != 2'b00);
        end
      end
      default: ;
    endcase
    if (load && state_q != S_BOOT) begin
      cnt_d = sat_inc(cnt_q);
      if (MAX_FETCH != 0 && cnt_d == CNT_LIMIT) state_d = S_HALT;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_BOOT;
      pend_q  <= '0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_next_o     = next_pc;
  assign pc_en_o       = load;
  assign flush_o       = flush;
  assign misalign_o    = mis_q;
  assign fetch_count_o = cnt_q;
  assign halted_o      = (state_q == S_HALT);

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Bench for fetch_pc_sequencer: directed vector table, corner sequences and a
// randomized run, two instances (default budget and a short budget) against one model.
module tb_fetch_pc_sequencer;

  localparam int          LIM_B = 5;
  localparam int          CW_A  = $clog2(100 + 2);
  localparam int          CW_B  = $clog2(LIM_B + 2);
  localparam logic [63:0] RV_A  = 64'h0;
  localparam logic [63:0] RV_B  = 64'h8000_0000;

  localparam int PH_BOOT = 0, PH_RUN = 1, PH_WAIT = 2, PH_HALT = 3;

  typedef struct {
    int          ph;
    logic [63:0] pend;
    bit          mis;
    int          cnt;
  } mdl_t;

  typedef struct {
    logic [63:0] nxt;
    bit          nchk;
    bit          en;
    bit          fl;
    bit          mis;
    int          cnt;
    bit          hlt;
  } exp_t;

  typedef struct {
    bit          rdy, stl, bv;
    logic [63:0] bt;
    bit          tv;
    logic [63:0] tt;
    bit          hl;
    bit          en;
    logic [63:0] nxt;
    bit          nchk;
    bit          fl;
    int          cnt;
    bit          mis;
    bit          hlt;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, rdy, stl, bv, tv, hl;
  logic [63:0]     bt, tt, pc_a, pc_b;
  logic [63:0]     nxt_a, nxt_b;
  logic            en_a, en_b, fl_a, fl_b, mis_a, mis_b, hlt_a, hlt_b;
  logic [CW_A-1:0] cnt_a;
  logic [CW_B-1:0] cnt_b;

  fetch_pc_sequencer u_a (
    .clk_i(clk), .reset_i(rst), .pc_cur_i(pc_a), .imem_ready_i(rdy), .stall_i(stl),
    .branch_valid_i(bv), .branch_target_i(bt), .trap_valid_i(tv), .trap_target_i(tt),
    .halt_i(hl), .pc_next_o(nxt_a), .pc_en_o(en_a), .flush_o(fl_a),
    .misalign_o(mis_a), .fetch_count_o(cnt_a), .halted_o(hlt_a)
  );

  fetch_pc_sequencer #(.RESET_VEC(RV_B), .MAX_FETCH(LIM_B)) u_b (
    .clk_i(clk), .reset_i(rst), .pc_cur_i(pc_b), .imem_ready_i(rdy), .stall_i(stl),
    .branch_valid_i(bv), .branch_target_i(bt), .trap_valid_i(tv), .trap_target_i(tt),
    .halt_i(hl), .pc_next_o(nxt_b), .pc_en_o(en_b), .flush_o(fl_b),
    .misalign_o(mis_b), .fetch_count_o(cnt_b), .halted_o(hlt_b)
  );

  int   checks = 0;
  int   errors = 0;
  mdl_t ma, mb;
  vec_t tbl[23];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference behaviour of one sequencer for the current inputs and PC.
  function automatic void model_eval(input mdl_t s, input int max, input int cmax,
                                     input logic [63:0] rv, input logic [63:0] pc,
                                     output exp_t e, output mdl_t n);
    bit          adv;
    logic [63:0] t;
    adv    = rdy && !stl;
    n      = s;
    e.nxt  = pc + 64'd4;
    e.nchk = 1'b0;
    e.en   = 1'b0;
    e.fl   = 1'b0;
    e.mis  = s.mis;
    e.cnt  = s.cnt;
    e.hlt  = (s.ph == PH_HALT);
    if (s.ph == PH_BOOT) begin
      e.nxt  = rv;
      e.nchk = 1'b1;
      e.en   = 1'b1;
      n.ph   = hl ? PH_HALT : PH_RUN;
      return;
    end
    if (s.ph == PH_HALT) return;
    if (hl) begin
      n.ph   = PH_HALT;
      n.pend = 64'h0;
      return;
    end
    if (s.ph == PH_RUN) begin
      if (tv || bv) begin
        t     = tv ? tt : bt;
        n.mis = s.mis || (t % 4 != 0);
        if (adv) begin
          e.nxt = t - (t % 4); e.nchk = 1'b1; e.en = 1'b1; e.fl = 1'b1;
        end else begin
          n.pend = t - (t % 4);
          n.ph   = PH_WAIT;
        end
      end else begin
        e.en   = adv;
        e.nchk = 1'b1;
      end
    end else begin
      if (adv) begin
        e.nxt  = tv ? tt - (tt % 4) : s.pend;
        e.nchk = 1'b1; e.en = 1'b1; e.fl = 1'b1;
        if (tv) n.mis = s.mis || (tt % 4 != 0);
        n.pend = 64'h0;
        n.ph   = PH_RUN;
      end else if (tv) begin
        n.pend = tt - (tt % 4);
        n.mis  = s.mis || (tt % 4 != 0);
      end
    end
    if (e.en) begin
      if (n.cnt < cmax) n.cnt = n.cnt + 1;
      if (max != 0 && n.cnt == max) n.ph = PH_HALT;
    end
  endfunction

  task automatic cmp_inst(input string tag, input exp_t e, input logic [63:0] nxt,
                          input logic en, input logic fl, input logic mis,
                          input logic hlt, input int cnt);
    chk({tag, ".pc_en"}, 64'(en), 64'(e.en));
    chk({tag, ".flush"}, 64'(fl), 64'(e.fl));
    chk({tag, ".misalign"}, 64'(mis), 64'(e.mis));
    chk({tag, ".halted"}, 64'(hlt), 64'(e.hlt));
    chk({tag, ".count"}, 64'(cnt), 64'(e.cnt));
    if (e.nchk) chk({tag, ".pc_next"}, nxt, e.nxt);
  endtask

  // One clock: compare at the falling edge, then advance model and PC registers.
  task automatic cycle(input bit use_vec, input vec_t v, input string vname);
    exp_t        ea, eb;
    mdl_t        na, nb;
    logic [63:0] ca, cb;
    logic        cea, ceb;
    @(negedge clk);
    model_eval(ma, 100, (1 << CW_A) - 1, RV_A, pc_a, ea, na);
    model_eval(mb, LIM_B, (1 << CW_B) - 1, RV_B, pc_b, eb, nb);
    cmp_inst("A", ea, nxt_a, en_a, fl_a, mis_a, hlt_a, int'(cnt_a));
    cmp_inst("B", eb, nxt_b, en_b, fl_b, mis_b, hlt_b, int'(cnt_b));
    if (use_vec) begin
      chk({vname, ".pc_en"}, 64'(en_a), 64'(v.en));
      chk({vname, ".flush"}, 64'(fl_a), 64'(v.fl));
      chk({vname, ".count"}, 64'(cnt_a), 64'(v.cnt));
      chk({vname, ".misalign"}, 64'(mis_a), 64'(v.mis));
      chk({vname, ".halted"}, 64'(hlt_a), 64'(v.hlt));
      if (v.nchk) chk({vname, ".pc_next"}, nxt_a, v.nxt);
    end
    ca = nxt_a; cea = en_a; cb = nxt_b; ceb = en_b;
    @(posedge clk);
    #1;
    ma = na;
    mb = nb;
    if (cea) pc_a = ca;
    if (ceb) pc_b = cb;
  endtask

  task automatic step();
    vec_t dummy;
    dummy = '{default: 0};
    cycle(1'b0, dummy, "");
  endtask

  task automatic set_in(input bit r, input bit s, input bit b, input logic [63:0] btv,
                        input bit t, input logic [63:0] ttv, input bit h);
    rdy = r; stl = s; bv = b; bt = btv; tv = t; tt = ttv; hl = h;
  endtask

  // Asynchronous reset: outputs must be in reset state before any clock edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst.A.pc_en", 64'(en_a), 64'd0);
    chk("rst.A.flush", 64'(fl_a), 64'd0);
    chk("rst.A.halted", 64'(hlt_a), 64'd0);
    chk("rst.A.count", 64'(cnt_a), 64'd0);
    chk("rst.A.misalign", 64'(mis_a), 64'd0);
    chk("rst.A.pc_next", nxt_a, RV_A);
    chk("rst.B.pc_en", 64'(en_b), 64'd0);
    chk("rst.B.halted", 64'(hlt_b), 64'd0);
    chk("rst.B.count", 64'(cnt_b), 64'd0);
    chk("rst.B.pc_next", nxt_b, RV_B);
    ma = '{PH_BOOT, 64'h0, 1'b0, 0};
    mb = '{PH_BOOT, 64'h0, 1'b0, 0};
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    pc_a = 64'h1000;
    pc_b = 64'h1000;
    set_in(1, 0, 0, 64'h0, 0, 64'h0, 0);

    //          rdy stl bv bt        tv tt       hl  en nxt       nchk fl cnt mis hlt
    tbl[0]  = '{1, 0, 0, 64'h0,   0, 64'h0,  0,  1, 64'h0,   1, 0, 0,  0, 0};
    tbl[1]  = '{1, 0, 0, 64'h0,   0, 64'h0,  0,  1, 64'h4,   1, 0, 0,  0, 0};
    tbl[2]  = '{1, 0, 0, 64'h0,   0, 64'h0,  0,  1, 64'h8,   1, 0, 1,  0, 0};
    tbl[3]  = '{1, 0, 0, 64'h0,   0, 64'h0,  0,  1, 64'hC,   1, 0, 2,  0, 0};
    tbl[4]  = '{1, 1, 0, 64'h0,   0, 64'h0,  0,  0, 64'h10,  1, 0, 3,  0, 0};
    tbl[5]  = '{1, 1, 0, 64'h0,   0, 64'h0,  0,  0, 64'h10,  1, 0, 3,  0, 0};
    tbl[6]  = '{1, 1, 0, 64'h0,   0, 64'h0,  0,  0, 64'h10,  1, 0, 3,  0, 0};
    tbl[7]  = '{1, 1, 1, 64'h200, 0, 64'h0,  0,  0, 64'h0,   0, 0, 3,  0, 0};
    tbl[8]  = '{1, 1, 1, 64'h200, 0, 64'h0,  0,  0, 64'h0,   0, 0, 3,  0, 0};
    tbl[9]  = '{1, 0, 0, 64'h0,   0, 64'h0,  0,  1, 64'h200, 1, 1, 3,  0, 0};
    tbl[10] = '{1, 0, 0, 64'h0,   0, 64'h0,  0,  1, 64'h204, 1, 0, 4,  0, 0};
    tbl[11] = '{1, 0, 1, 64'h200, 1, 64'h80, 0,  1, 64'h80,  1, 1, 5,  0, 0};
    tbl[12] = '{1, 1, 1, 64'h300, 0, 64'h0,  0,  0, 64'h0,   0, 0, 6,  0, 0};
    tbl[13] = '{1, 1, 0, 64'h0,   1, 64'h90, 0,  0, 64'h0,   0, 0, 6,  0, 0};
    tbl[14] = '{1, 0, 0, 64'h0,   0, 64'h0,  0,  1, 64'h90,  1, 1, 6,  0, 0};
    tbl[15] = '{1, 0, 0, 64'h0,   0, 64'h0,  0,  1, 64'h94,  1, 0, 7,  0, 0};
    tbl[16] = '{1, 1, 1, 64'h400, 0, 64'h0,  0,  0, 64'h0,   0, 0, 8,  0, 0};
    tbl[17] = '{1, 0, 0, 64'h0,   1, 64'hA0, 0,  1, 64'hA0,  1, 1, 8,  0, 0};
    tbl[18] = '{1, 0, 1, 64'h103, 0, 64'h0,  0,  1, 64'h100, 1, 1, 9,  0, 0};
    tbl[19] = '{1, 0, 0, 64'h0,   0, 64'h0,  0,  1, 64'h104, 1, 0, 10, 1, 0};
    tbl[20] = '{0, 0, 0, 64'h0,   0, 64'h0,  0,  0, 64'h108, 1, 0, 11, 1, 0};
    tbl[21] = '{1, 0, 1, 64'h500, 0, 64'h0,  1,  0, 64'h0,   0, 0, 11, 1, 0};
    tbl[22] = '{1, 0, 1, 64'h600, 1, 64'h700,0,  0, 64'h0,   0, 0, 11, 1, 1};

    #2;
    do_reset();
    for (int i = 0; i < 23; i++) begin
      set_in(tbl[i].rdy, tbl[i].stl, tbl[i].bv, tbl[i].bt, tbl[i].tv, tbl[i].tt, tbl[i].hl);
      cycle(1'b1, tbl[i], $sformatf("vec%0d", i));
    end

    // halt requested during BOOT: the boot load still happens, then HALT
    do_reset();
    set_in(1, 0, 0, 64'h0, 0, 64'h0, 1);
    step();
    set_in(1, 0, 1, 64'h40, 0, 64'h0, 0);
    #1;
    chk("boot_halt.halted", 64'(hlt_a), 64'd1);
    chk("boot_halt.pc_en", 64'(en_a), 64'd0);
    step();

    // sequential increment wraps at the top of the address space
    do_reset();
    set_in(1, 0, 0, 64'h0, 0, 64'h0, 0);
    step();
    pc_a = 64'hFFFF_FFFF_FFFF_FFFC;
    pc_b = 64'hFFFF_FFFF_FFFF_FFFC;
    #1;
    chk("wrap.pc_next", nxt_a, 64'h0);
    chk("wrap.pc_en", 64'(en_a), 64'd1);
    step();

    // short budget: five loads after BOOT, then HALT ignores redirects
    do_reset();
    set_in(1, 0, 0, 64'h0, 0, 64'h0, 0);
    for (int i = 0; i < 6; i++) step();
    set_in(1, 0, 1, 64'h40, 1, 64'h44, 0);
    #1;
    chk("budget.halted", 64'(hlt_b), 64'd1);
    chk("budget.count", 64'(cnt_b), 64'd5);
    chk("budget.pc_en", 64'(en_b), 64'd0);
    chk("budget.flush", 64'(fl_b), 64'd0);
    step();
    step();
    do_reset();

    // randomized traffic with occasional resets and near-wrap PCs
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      set_in($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 6) == 0, {$urandom(), $urandom()},
             $urandom_range(0, 11) == 0, {$urandom(), $urandom()},
             $urandom_range(0, 149) == 0);
      if ($urandom_range(0, 99) == 0) begin
        pc_a = 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 1) * 4);
        pc_b = pc_a;
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
